ece453_seg7_scan: RTL and testbench

- Downstream display stage for the ece453 register block. Consumes the FSM state and GPIO-out values that software or the FSM publish.
- Drives a time-multiplexed common-anode 7-segment display with double-buffered updates, anti-ghost blanking and leading-zero suppression.
- Sits between the ece453 register block outputs and the board segment/anode pins.

---
 rtl/ece453_seg7_pkg.sv | 43 ++++
 rtl/ece453_hex_to_seg7.sv | 9 +
 rtl/ece453_seg7_scan.sv | 105 ++++++++++
 tb/tb_ece453_seg7_scan.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ece453_seg7_pkg.sv
// ece453_seg7_pkg: shared segment bit positions and the hex-to-segment font table.
package ece453_seg7_pkg;
  typedef logic [6:0] seg_t;
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;
  localparam seg_t SEG_OFF = 7'h00;
  function automatic seg_t segs(input logic a, b, c, d, e, f, g);
    seg_t s;
    s = SEG_OFF;
    s[SEG_A] = a;
    s[SEG_B] = b;
    s[SEG_C] = c;
    s[SEG_D] = d;
    s[SEG_E] = e;
    s[SEG_F] = f;
    s[SEG_G] = g;
    return s;
  endfunction
  // Active-high patterns, entry 15 first.
  localparam logic [15:0][6:0] HEX_SEG = {
    segs(1, 0, 0, 0, 1, 1, 1),
    segs(1, 0, 0, 1, 1, 1, 1),
    segs(0, 1, 1, 1, 1, 0, 1),
    segs(1, 0, 0, 1, 1, 1, 0),
    segs(0, 0, 1, 1, 1, 1, 1),
    segs(1, 1, 1, 0, 1, 1, 1),
    segs(1, 1, 1, 1, 0, 1, 1),
    segs(1, 1, 1, 1, 1, 1, 1),
    segs(1, 1, 1, 0, 0, 0, 0),
    segs(1, 0, 1, 1, 1, 1, 1),
    segs(1, 0, 1, 1, 0, 1, 1),
    segs(0, 1, 1, 0, 0, 1, 1),
    segs(1, 1, 1, 1, 0, 0, 1),
    segs(1, 1, 0, 1, 1, 0, 1),
    segs(0, 1, 1, 0, 0, 0, 0),
    segs(1, 1, 1, 1, 1, 1, 0)
  };
endpackage

// File: rtl/ece453_hex_to_seg7.sv
// ece453_hex_to_seg7: combinational nibble to active-high segment pattern.
module ece453_hex_to_seg7
  import ece453_seg7_pkg::*;
(
  input  logic [3:0] nib,
  output seg_t       seg
);
  assign seg = HEX_SEG[nib];
endmodule

// File: rtl/ece453_seg7_scan.sv
// ece453_seg7_scan: double-buffered multiplexed 7-segment driver with anti-ghost blanking.
module ece453_seg7_scan
  import ece453_seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter bit ACTIVE_LOW   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_blank,
  input  logic                    load,
  output logic                    update_pending,
  output logic                    update_done,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an
);
  localparam int DW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam seg_t SEG_INACT = {7{ACTIVE_LOW}} ^ SEG_OFF;
  localparam logic [NUM_DIGITS-1:0] AN_INACT = {NUM_DIGITS{ACTIVE_LOW}};
  logic [DW-1:0] div_q, div_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] pval_q, pval_d, aval_q, aval_d;
  logic [NUM_DIGITS-1:0] pdp_q, pdp_d, adp_q, adp_d;
  logic pend_q, pend_d, done_q, done_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  seg_t seg_q, seg_d;
  logic dp_q, dp_d;
  logic wrap, frame, xfer, lit, show, run;
  logic [NUM_DIGITS-1:0] blank;
  logic [3:0] nib;
  seg_t dec;
  ece453_hex_to_seg7 u_dec (
    .nib(nib),
    .seg(dec)
  );
  always_comb begin
    wrap = enable && div_q == DW'(SCAN_DIV - 1);
    frame = wrap && idx_q == IW'(NUM_DIGITS - 1);
    xfer = frame && pend_q;
    div_d = wrap || !enable ? '0 : div_q + 1'b1;
    idx_d = frame || !enable ? '0 : wrap ? idx_q + 1'b1 : idx_q;
    pval_d = load ? value_in : pval_q;
    pdp_d = load ? dp_in : pdp_q;
    aval_d = xfer ? pval_q : aval_q;
    adp_d = xfer ? pdp_q : adp_q;
    pend_d = load || (pend_q && !xfer);
    done_d = xfer;
  end
  // Zero run from the most significant digit down; digit 0 always stays visible.
  always_comb begin
    blank = '0;
    run = lz_blank;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run = run && aval_q[4*i +: 4] == 4'h0 && !adp_q[i];
      blank[i] = run && i != 0;
    end
  end
  always_comb begin
    nib = aval_q[{idx_q, 2'b00} +: 4];
    lit = enable && div_q >= DW'(BLANK_CYCLES);
    show = lit && !blank[idx_q];
    an_d = AN_INACT ^ (lit ? NUM_DIGITS'(1) << idx_q : '0);
    seg_d = SEG_INACT ^ (show ? dec : SEG_OFF);
    dp_d = ACTIVE_LOW ^ (show && adp_q[idx_q]);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= '0;
      idx_q <= '0;
      pval_q <= '0;
      pdp_q <= '0;
      aval_q <= '0;
      adp_q <= '0;
      pend_q <= 1'b0;
      done_q <= 1'b0;
      an_q <= AN_INACT;
      seg_q <= SEG_INACT;
      dp_q <= ACTIVE_LOW;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
      pval_q <= pval_d;
      pdp_q <= pdp_d;
      aval_q <= aval_d;
      adp_q <= adp_d;
      pend_q <= pend_d;
      done_q <= done_d;
      an_q <= an_d;
      seg_q <= seg_d;
      dp_q <= dp_d;
    end
  end
  assign update_pending = pend_q;
  assign update_done = done_q;
  assign an = an_q;
  assign seg = seg_q;
  assign dp = dp_q;
endmodule

// File: tb/tb_ece453_seg7_scan.sv
// tb_ece453_seg7_scan: scoreboard bench against a frame-level display model.
module tb_ece453_seg7_scan;
  localparam int N = 4;
  localparam int DIV = 8;
  localparam int BLK = 2;
  localparam int FRAME = N * DIV;
  localparam logic [6:0] FONT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                       7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic lz_blank = 1'b0;
  logic load = 1'b0;
  logic [15:0] value_in = '0;
  logic [3:0] dp_in = '0;
  logic update_pending, update_done, dp;
  logic [6:0] seg;
  logic [3:0] an;
  ece453_seg7_scan #(
    .NUM_DIGITS(N),
    .SCAN_DIV(DIV),
    .BLANK_CYCLES(BLK),
    .ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .value_in(value_in),
    .dp_in(dp_in),
    .lz_blank(lz_blank),
    .load(load),
    .update_pending(update_pending),
    .update_done(update_done),
    .seg(seg),
    .dp(dp),
    .an(an)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic pend;
    logic done;
    logic [3:0] an;
    logic [6:0] seg;
    logic dp;
  } obs_t;
  obs_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int mt = 0;
  logic mpend = 1'b0;
  logic [15:0] mpv = '0, mav = '0;
  logic [3:0] mpd = '0, mad = '0;
  // mt counts enabled cycles: slot = mt / DIV, digit = slot mod N, phase = mt mod DIV.
  task automatic model_step();
    obs_t e;
    int ph, dg;
    logic off, xfer;
    ph = mt % DIV;
    dg = (mt / DIV) % N;
    e.an = 4'hF;
    e.seg = 7'h7F;
    e.dp = 1'b1;
    if (enable && ph >= BLK) begin
      off = lz_blank && dg > 0 && (mav >> (4 * dg)) == 16'h0 && (mad >> dg) == 4'h0;
      e.an = ~(4'b0001 << dg);
      e.seg = off ? 7'h7F : FONT[mav[4*dg +: 4]];
      e.dp = off ? 1'b1 : ~mad[dg];
    end
    xfer = enable && ph == DIV - 1 && dg == N - 1 && mpend;
    if (xfer) begin
      mav = mpv;
      mad = mpd;
      mpend = 1'b0;
    end
    if (load) begin
      mpv = value_in;
      mpd = dp_in;
      mpend = 1'b1;
    end
    e.pend = mpend;
    e.done = xfer;
    exp_q.push_back(e);
    mt = enable ? mt + 1 : 0;
  endtask
  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      exp_q.delete();
      mt = 0;
      mpend = 1'b0;
      mpv = '0;
      mpd = '0;
      mav = '0;
      mad = '0;
    end else model_step();
  end
  initial forever begin
    obs_t e, got;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = {update_pending, update_done, an, seg, dp};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL out t=%0t got pend=%b done=%b an=%b seg=%b dp=%b, want pend=%b done=%b an=%b seg=%b dp=%b",
                 $time, got.pend, got.done, got.an, got.seg, got.dp, e.pend, e.done, e.an, e.seg, e.dp);
      end
    end
  end
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value_in = v;
    dp_in = d;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask
  task automatic wait_phase(input int p, input string nm);
    int k;
    k = 0;
    while (mt % FRAME != p && k < 4 * FRAME) begin
      @(negedge clk);
      k++;
    end
    if (k >= 4 * FRAME) chk({nm, "_timeout"}, 32'(k), 32'(4 * FRAME - 1));
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    cyc(3);
    chk("reset_state", {20'h0, update_pending, update_done, an, seg, dp}, {20'h0, 2'b00, 4'hF, 7'h7F, 1'b1});
    reset = 1'b0;
    cyc(4);
    enable = 1'b1;
    cyc(2 * FRAME);
    lz_blank = 1'b1;
    cyc(FRAME);
    lz_blank = 1'b0;
    wait_phase(12, "mid_frame");
    do_load(16'h12AF, 4'b0100);
    cyc(2 * FRAME);
    wait_phase(2, "double_load");
    do_load(16'h1111, 4'b0000);
    cyc(3);
    do_load(16'h2222, 4'b0000);
    cyc(2 * FRAME);
    lz_blank = 1'b1;
    do_load(16'h0050, 4'b0000);
    cyc(2 * FRAME);
    do_load(16'h0000, 4'b0000);
    cyc(2 * FRAME);
    do_load(16'h9C3E, 4'b1001);
    wait_phase(FRAME - 1, "boundary");
    do_load(16'h0B7D, 4'b0010);
    chk("boundary_pend_done", {30'h0, update_pending, update_done}, 32'h3);
    cyc(2 * FRAME);
    for (int i = 0; i < 600; i++) begin
      load = $urandom_range(0, 19) == 0;
      value_in = 16'($urandom() >> (4 * $urandom_range(4, 8)));
      dp_in = $urandom_range(0, 3) == 0 ? 4'($urandom()) : 4'h0;
      if ($urandom_range(0, 99) == 0) lz_blank = ~lz_blank;
      enable = $urandom_range(0, 99) != 0;
      @(negedge clk);
    end
    load = 1'b0;
    enable = 1'b1;
    cyc(FRAME);
    wait_phase(20, "slot2");
    chk("slot2_anode", {28'h0, an}, 32'hB);
    #1 reset = 1'b1;
    #1 chk("reset_async", {20'h0, update_pending, update_done, an, seg, dp}, {20'h0, 2'b00, 4'hF, 7'h7F, 1'b1});
    @(negedge clk);
    reset = 1'b0;
    cyc(2 * FRAME);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
